// File: rtl/m_dmem_lsu_if.sv
// -----------------------------------------------------------------------------
// m_dmem_lsu_if
// Request/response bundle between the memory-access stage (master) and the
// load/store data memory (slave).
//   w_req_valid/w_req_ready : request handshake; accepted when both are high
//   w_req_we                : 1 = store, 0 = load
//   w_req_funct3            : RV32I width code (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   w_req_addr              : byte address
//   w_req_wdata             : store data (low bits used for SB/SH)
//   w_rsp_valid             : one-cycle response pulse
//   w_rsp_rdata             : extended load data; 0 for stores and errors
//   w_rsp_err               : misaligned access or illegal funct3
//   w_busy                  : request in flight
// -----------------------------------------------------------------------------
interface m_dmem_lsu_if;
  logic        w_req_valid;
  logic        w_req_ready;
  logic        w_req_we;
  logic [2:0]  w_req_funct3;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_err;
  logic        w_busy;

  modport master (
    output w_req_valid, w_req_we, w_req_funct3, w_req_addr, w_req_wdata,
    input  w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err, w_busy
  );

  modport slave (
    input  w_req_valid, w_req_we, w_req_funct3, w_req_addr, w_req_wdata,
    output w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err, w_busy
  );
endinterface

// File: rtl/m_dmem_lsu.sv
// -----------------------------------------------------------------------------
// m_dmem_lsu
// RV32I load/store data memory with configurable access latency.
// A request is latched on acceptance, waits LATENCY edges, then the memory is
// read/written and a registered response is presented for one cycle.
// Ports:
//   w_clk   : clock, rising edge
//   w_rst_n : asynchronous active-low reset (does not clear the memory array)
//   bus     : m_dmem_lsu_if.slave request/response bundle
// Parameters:
//   ADDR_W  : word-address bits, depth = 2**ADDR_W 32-bit words
//   LATENCY : edges from acceptance to memory commit, 1..16
// -----------------------------------------------------------------------------
module m_dmem_lsu #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic         w_clk,
  input  logic         w_rst_n,
  m_dmem_lsu_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;

  // Contents start at zero and survive reset.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic              accept;
  logic              commit;
  logic              legal;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ld_data;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;

  // Upper address bits are intentionally dropped: addresses wrap on the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.w_req_addr[31:ADDR_W+2];

  // Handshake outputs depend on state only, never on w_req_valid.
  assign bus.w_req_ready = (state != S_WAIT);
  assign bus.w_busy      = (state == S_WAIT);
  assign bus.w_rsp_valid = (state == S_RESP);

  assign accept = bus.w_req_valid & bus.w_req_ready;
  assign commit = (state == S_WAIT) && (cnt == 4'd0);

  assign idx     = r_addr[ADDR_W+1:2];
  assign lane    = r_addr[1:0];
  assign rd_word = mem[idx];

  // Decode of the latched request: legality, load extraction, store lanes.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    legal    = 1'b0;
    ld_data  = '0;
    wr_mask  = '0;
    wr_data  = r_wdata;
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = r_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (r_f3)
      3'b000: begin
        legal   = 1'b1;
        ld_data = {{24{byte_sel[7]}}, byte_sel};
        wr_mask = 4'b0001 << lane;
        wr_data = {4{r_wdata[7:0]}};
      end
      3'b001: begin
        legal   = ~r_addr[0];
        ld_data = {{16{half_sel[15]}}, half_sel};
        wr_mask = r_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{r_wdata[15:0]}};
      end
      3'b010: begin
        legal   = (lane == 2'b00);
        ld_data = rd_word;
        wr_mask = 4'b1111;
      end
      3'b100: begin
        legal   = ~r_we;
        ld_data = {24'd0, byte_sel};
      end
      3'b101: begin
        legal   = ~r_we & ~r_addr[0];
        ld_data = {16'd0, half_sel};
      end
      default: legal = 1'b0;
    endcase
  end

  // Control state, request latch and registered response.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      r_we            <= 1'b0;
      r_f3            <= '0;
      r_addr          <= '0;
      r_wdata         <= '0;
      bus.w_rsp_rdata <= '0;
      bus.w_rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            state   <= S_WAIT;
            cnt     <= CNT_LOAD;
            r_we    <= bus.w_req_we;
            r_f3    <= bus.w_req_funct3;
            r_addr  <= bus.w_req_addr[ADDR_W+1:0];
            r_wdata <= bus.w_req_wdata;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state           <= S_RESP;
            bus.w_rsp_rdata <= (legal && !r_we) ? ld_data : 32'd0;
            bus.w_rsp_err   <= ~legal;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory array write port. A reset during WAIT forces IDLE, so an
  // uncommitted store never reaches here.
  // NOTE: the array has no reset branch; clearing it on reset would turn it
  // into a bank of flops instead of a RAM and break the retention contract.
  always_ff @(posedge w_clk) begin
    if (commit && r_we && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
